// File: rtl/cu_seq_pkg.sv
// cu_seq_pkg: micro-word encodings, default control-store image and opcode dispatch
// table shared by cu_microsequencer (ROM build, or RAM build under CU_WCS_EN).
package cu_seq_pkg;

   localparam int SEQ_W = 3;

   typedef enum logic [SEQ_W-1:0] {
      SEQ_NEXT = 3'b000,
      SEQ_MAP  = 3'b001,
      SEQ_ZERO = 3'b010,
      SEQ_JUMP = 3'b011,
      SEQ_BRC  = 3'b100,
      SEQ_CALL = 3'b101,
      SEQ_RET  = 3'b110,
      SEQ_HALT = 3'b111
   } seq_op_t;

   typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_HALT} seq_state_t;

   // Width-generic micro-word; each sequencer instance packs it into its own layout.
   typedef struct packed {
      seq_op_t     op;
      logic [7:0]  cond_sel;
      logic [15:0] addr;
      logic [31:0] payload;
   } uword_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n == 0) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int unsigned cw_width(input int unsigned car_w, input int unsigned pay_w,
                                            input int unsigned cond_n);
      return SEQ_W + idx_width(cond_n) + car_w + pay_w;
   endfunction

   function automatic uword_t uw(input seq_op_t op, input int unsigned cs,
                                 input int unsigned tgt, input int unsigned a);
      uword_t u;
      u.op       = op;
      u.cond_sel = 8'(cs);
      u.addr     = 16'(tgt);
      u.payload  = 32'h0015_A5A5 ^ (a * 32'h0000_0901);
      return u;
   endfunction

   function automatic uword_t default_image(input int unsigned a);
      case (a)
         0, 1:    return uw(SEQ_NEXT, 0, 0, a);
         2:       return uw(SEQ_MAP,  0, 0, a);
         'h0B:    return uw(SEQ_BRC,  0, 'h1F, a);
         'h0C:    return uw(SEQ_BRC,  1, 'h1F, a);
         'h10:    return uw(SEQ_CALL, 0, 'h40, a);
         'h14:    return uw(SEQ_RET,  0, 0, a);
         'h18:    return uw(SEQ_JUMP, 0, 'h1A, a);
         'h1A:    return uw(SEQ_NEXT, 0, 0, a);
         'h1C:    return uw(SEQ_JUMP, 0, 'h7F, a);
         'h20:    return uw(SEQ_HALT, 0, 0, a);
         'h21:    return uw(SEQ_NEXT, 0, 0, a);
         'h40:    return uw(SEQ_CALL, 0, 'h48, a);
         'h48:    return uw(SEQ_CALL, 0, 'h50, a);
         'h50:    return uw(SEQ_CALL, 0, 'h58, a);
         'h58:    return uw(SEQ_CALL, 0, 'h60, a);
         'h41, 'h49, 'h51, 'h59, 'h60:
                  return uw(SEQ_RET,  0, 0, a);
         'h7F:    return uw(SEQ_NEXT, 0, 0, a);
         default: return uw(SEQ_ZERO, 0, 0, a);
      endcase
   endfunction

   function automatic logic [15:0] dispatch_map(input logic [31:0] opc);
      case (opc)
         32'd1:   return 16'h0B;
         32'd2:   return 16'h10;
         32'd3:   return 16'h14;
         32'd4:   return 16'h18;
         32'd5:   return 16'h1C;
         32'd6:   return 16'h20;
         32'd7:   return 16'h21;
         default: return 16'h00;
      endcase
   endfunction

endpackage

// File: rtl/cu_microsequencer_ustack.sv
// cu_ustack: synchronous LIFO of micro-subroutine return addresses.
// A push when full and a pop when empty are ignored; the caller flags the error.
module cu_ustack
   import cu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PTR_W = cnt_width(DEPTH);
   localparam int IDX_W = idx_width(DEPTH);

   logic [W-1:0]     ents [DEPTH];
   logic [PTR_W-1:0] sp;

   assign full  = (sp == PTR_W'(DEPTH));
   assign empty = (sp == '0);
   assign dout  = empty ? '0 : ents[IDX_W'(sp - PTR_W'(1))];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sp <= '0;
      else if (push && !full)
         sp <= sp + PTR_W'(1);
      else if (pop && !empty)
         sp <= sp - PTR_W'(1);
   end

   // NOTE: entry storage has no reset; sp alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push && !full)
         ents[sp[IDX_W-1:0]] <= din;
   end

endmodule

// File: rtl/cu_microsequencer.sv
// cu_microsequencer: CAR/MIR microprogram sequencer with branch, call/return, stall and halt.
// Define CU_WCS_EN for a writable control store (RAM plus i_wcs_* ports); default is ROM.
module cu_microsequencer
   import cu_seq_pkg::*;
#(
   parameter int   CAR_W       = 7,
   parameter int   PAY_W       = 21,
   parameter int   OPC_W       = 8,
   parameter int   COND_N      = 4,
   parameter int   STACK_DEPTH = 4,
   localparam int  CS_W        = idx_width(COND_N),
   localparam int  CW_W        = cw_width(CAR_W, PAY_W, COND_N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] i_opcode,
   input  logic [COND_N-1:0] i_cond,
   input  logic             i_stall,
   output logic [CAR_W-1:0] o_car,
   output logic [PAY_W-1:0] o_ctrl,
   output logic             o_halted,
   output logic             o_stack_err
`ifdef CU_WCS_EN
   ,
   input  logic             i_wcs_we,
   input  logic [CAR_W-1:0] i_wcs_addr,
   input  logic [CW_W-1:0]  i_wcs_data
`endif
);
   localparam int DEPTH   = 2**CAR_W;
   localparam int COND_P2 = 2**CS_W;
   localparam int CS_LSB  = PAY_W + CAR_W;
   localparam int OP_LSB  = CS_LSB + CS_W;

   seq_state_t        state, next_state;
   logic [CAR_W-1:0]  car, next_car, car_inc, stk_top, mir_addr;
   logic [CW_W-1:0]   mir, rd_word;
   logic [PAY_W-1:0]  mir_pay, ctrl;
   logic [CS_W-1:0]   mir_cs;
   logic [COND_P2-1:0] cond_ext;
   seq_op_t           mir_op;
   logic              stack_err, err_set, load, push, pop, stk_full, stk_empty;

   function automatic logic [CW_W-1:0] pack_word(input uword_t u);
      return {u.op, u.cond_sel[CS_W-1:0], u.addr[CAR_W-1:0], u.payload[PAY_W-1:0]};
   endfunction

   assign mir_op   = seq_op_t'(mir[OP_LSB +: SEQ_W]);
   assign mir_cs   = mir[CS_LSB +: CS_W];
   assign mir_addr = mir[PAY_W +: CAR_W];
   assign mir_pay  = mir[0 +: PAY_W];
   assign car_inc  = car + CAR_W'(1);
   // Zero-extension makes any cond_sel at or above COND_N read as false.
   assign cond_ext = COND_P2'(i_cond);

`ifdef CU_WCS_EN
   typedef logic [CW_W-1:0] store_t [DEPTH];

   function automatic store_t init_store();
      store_t s;
      for (int a = 0; a < DEPTH; a++)
         s[a] = pack_word(default_image(a));
      return s;
   endfunction

   // Power-up contents come from the declaration initialiser; the RAM is never reset.
   store_t store = init_store();

   always_ff @(posedge clk) begin
      if (i_wcs_we)
         store[i_wcs_addr] <= i_wcs_data;
   end

   assign rd_word = store[next_car];
`else
   assign rd_word = pack_word(default_image(32'(next_car)));
`endif

   cu_ustack #(.DEPTH(STACK_DEPTH), .W(CAR_W)) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (car_inc),
      .dout  (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // NOTE: every signal written here gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      next_car   = car;
      ctrl       = '0;
      load       = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      err_set    = 1'b0;
      case (state)
         ST_FILL: begin
            next_state = ST_RUN;
            next_car   = '0;
            load       = 1'b1;
         end
         ST_RUN: begin
            if (!i_stall) begin
               ctrl = mir_pay;
               load = 1'b1;
               case (mir_op)
                  SEQ_NEXT: next_car = car_inc;
                  SEQ_MAP:  next_car = CAR_W'(dispatch_map(32'(i_opcode)));
                  SEQ_ZERO: next_car = '0;
                  SEQ_JUMP: next_car = mir_addr;
                  SEQ_BRC:  next_car = cond_ext[mir_cs] ? mir_addr : car_inc;
                  SEQ_CALL: begin
                     next_car = mir_addr;
                     err_set  = stk_full;
                     push     = !stk_full;
                  end
                  SEQ_RET: begin
                     next_car = stk_empty ? '0 : stk_top;
                     err_set  = stk_empty;
                     pop      = !stk_empty;
                  end
                  SEQ_HALT: begin
                     next_state = ST_HALT;
                     load       = 1'b0;
                  end
                  default: next_car = '0;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_FILL;
         car       <= '0;
         mir       <= '0;
         stack_err <= 1'b0;
      end else begin
         state     <= next_state;
         stack_err <= stack_err | err_set;
         if (load) begin
            car <= next_car;
            mir <= rd_word;
         end
      end
   end

   assign o_car       = car;
   assign o_ctrl      = ctrl;
   assign o_halted    = (state == ST_HALT);
   assign o_stack_err = stack_err;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Randomised scoreboard bench for cu_microsequencer against a queue-based behavioural model.
// Define CU_WCS_EN to also exercise a control-store write during execution.
module tb_cu_microsequencer;
   import cu_seq_pkg::*;

   localparam int CAR_W       = 7;
   localparam int PAY_W       = 21;
   localparam int OPC_W       = 8;
   localparam int COND_N      = 4;
   localparam int STACK_DEPTH = 4;
   localparam int DEPTH       = 128;
   localparam int NCYC        = 4000;

   logic             clk = 1'b0;
   logic             rst;
   logic [OPC_W-1:0] i_opcode;
   logic [COND_N-1:0] i_cond;
   logic             i_stall;
   logic [CAR_W-1:0] o_car;
   logic [PAY_W-1:0] o_ctrl;
   logic             o_halted;
   logic             o_stack_err;
`ifdef CU_WCS_EN
   logic             i_wcs_we;
   logic [CAR_W-1:0] i_wcs_addr;
   logic [32:0]      i_wcs_data;
   bit               wcs_done;
`endif

   cu_microsequencer #(
      .CAR_W(CAR_W), .PAY_W(PAY_W), .OPC_W(OPC_W), .COND_N(COND_N), .STACK_DEPTH(STACK_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_opcode    (i_opcode),
      .i_cond      (i_cond),
      .i_stall     (i_stall),
      .o_car       (o_car),
      .o_ctrl      (o_ctrl),
      .o_halted    (o_halted),
      .o_stack_err (o_stack_err)
`ifdef CU_WCS_EN
      ,
      .i_wcs_we    (i_wcs_we),
      .i_wcs_addr  (i_wcs_addr),
      .i_wcs_data  (i_wcs_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int car; int ctrl; bit halted; bit err; } exp_t;
   typedef enum { M_FILL, M_RUN, M_HALT } mstate_e;

   exp_t    sb[$];
   int      n_checks = 0;
   int      n_errors = 0;

   mstate_e m_st;
   int      m_car;
   uword_t  m_mir;
   uword_t  m_mem [DEPTH];
   int      m_stack[$];
   bit      m_err;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st  = M_FILL;
      m_car = 0;
      m_mir = '0;
      m_stack.delete();
      m_err = 1'b0;
   endtask

   function automatic exp_t m_outputs(input logic stall);
      exp_t e;
      e.car    = m_car;
      e.ctrl   = (m_st == M_RUN && !stall) ? int'(m_mir.payload[PAY_W-1:0]) : 0;
      e.halted = (m_st == M_HALT);
      e.err    = m_err;
      return e;
   endfunction

   // Behavioural effect of one clock edge on the sequencer.
   task automatic m_advance(input logic [OPC_W-1:0] opc, input logic [COND_N-1:0] cond,
                            input logic stall);
      int nxt;
      case (m_st)
         M_FILL: begin
            m_st  = M_RUN;
            m_car = 0;
            m_mir = m_mem[0];
         end
         M_RUN: if (!stall) begin
            nxt = (m_car + 1) % DEPTH;
            case (m_mir.op)
               SEQ_MAP:  nxt = int'(dispatch_map(32'(opc))) % DEPTH;
               SEQ_ZERO: nxt = 0;
               SEQ_JUMP: nxt = int'(m_mir.addr);
               SEQ_BRC:
                  if (int'(m_mir.cond_sel) < COND_N && ((int'(cond) >> m_mir.cond_sel) % 2) == 1)
                     nxt = int'(m_mir.addr);
               SEQ_CALL: begin
                  if (m_stack.size() == STACK_DEPTH) m_err = 1'b1;
                  else m_stack.push_back((m_car + 1) % DEPTH);
                  nxt = int'(m_mir.addr);
               end
               SEQ_RET: begin
                  if (m_stack.size() == 0) begin
                     m_err = 1'b1;
                     nxt   = 0;
                  end else begin
                     nxt = m_stack.pop_back();
                  end
               end
               SEQ_HALT: m_st = M_HALT;
               default: ;
            endcase
            if (m_st == M_RUN) begin
               m_car = nxt;
               m_mir = m_mem[nxt];
            end
         end
         default: ;
      endcase
   endtask

   // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("o_car",       int'(o_car),       e.car);
            check("o_ctrl",      int'(o_ctrl),      e.ctrl);
            check("o_halted",    int'(o_halted),    int'(e.halted));
            check("o_stack_err", int'(o_stack_err), int'(e.err));
         end
      end
   end

   initial begin
      int halted_for;
      int stall_left;
      int v;
      rst        = 1'b1;
      i_opcode   = '0;
      i_cond     = '0;
      i_stall    = 1'b0;
      halted_for = 0;
      stall_left = 0;
`ifdef CU_WCS_EN
      i_wcs_we   = 1'b0;
      i_wcs_addr = '0;
      i_wcs_data = '0;
      wcs_done   = 1'b0;
`endif
      for (int a = 0; a < DEPTH; a++) m_mem[a] = default_image(a);
      m_reset();

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc < 2)
            rst = 1'b1;
         else if (rst)
            rst = 1'b0;
         else if (halted_for > 4 || $urandom_range(0, 199) == 0)
            rst = 1'b1;

         i_cond = COND_N'($urandom);
         if ($urandom_range(0, 99) < 3) begin
            i_opcode = 8'd6;
         end else begin
            v = $urandom_range(0, 8);
            if (v >= 6) v++;
            i_opcode = OPC_W'(v);
         end

         if (stall_left > 0) begin
            i_stall = 1'b1;
            stall_left--;
         end else if ($urandom_range(0, 9) == 0) begin
            i_stall    = 1'b1;
            stall_left = $urandom_range(0, 2);
         end else begin
            i_stall = 1'b0;
         end
         if (m_st == M_FILL || (m_st == M_RUN && m_mir.op == SEQ_HALT))
            i_stall = 1'b0;

`ifdef CU_WCS_EN
         i_wcs_we = 1'b0;
         if (!rst && cyc >= 500 && !wcs_done && m_st == M_RUN && !i_stall && m_mir.op == SEQ_MAP) begin
            i_opcode   = 8'd7;
            i_wcs_we   = 1'b1;
            i_wcs_addr = 7'h21;
            i_wcs_data = {SEQ_JUMP, 2'b00, 7'h05, 21'h0ABCDE};
            wcs_done   = 1'b1;
         end
`endif

         if (rst) m_reset();
         sb.push_back(m_outputs(i_stall));
         if (!rst) m_advance(i_opcode, i_cond, i_stall);

`ifdef CU_WCS_EN
         if (i_wcs_we) begin
            m_mem[33].op       = SEQ_JUMP;
            m_mem[33].cond_sel = 8'h00;
            m_mem[33].addr     = 16'h0005;
            m_mem[33].payload  = 32'h000A_BCDE;
         end
`endif
         halted_for = (m_st == M_HALT) ? halted_for + 1 : 0;
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
